// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the core run/debug sequencer.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_HALTED  = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_CPU_RST = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_RUN       = 3'd0,
    OP_STEP      = 3'd1,
    OP_HALT      = 3'd2,
    OP_SET_BP    = 3'd3,
    OP_CLR_BP    = 3'd4,
    OP_SET_LIMIT = 3'd5,
    OP_RST       = 3'd6,
    OP_ILL       = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_CMD      = 3'd1,
    CAUSE_SENTINEL = 3'd2,
    CAUSE_BREAK    = 3'd3,
    CAUSE_LIMIT    = 3'd4,
    CAUSE_STEP     = 3'd5
  } cause_e;

  localparam logic [31:0] HALT_PC_DEF = 32'hfffffffc;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host/debug command port: valid/ready command channel plus drop indication.
interface cpu_run_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_err;

  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready, cmd_err);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready, cmd_err);
endinterface

// File: rtl/cpu_stop_detect.sv
// Combinational stop condition and prioritised cause for the current PC.
module cpu_stop_detect
  import cpu_dbg_pkg::*;
#(
  parameter logic [31:0] HALT_PC = HALT_PC_DEF
) (
  input  logic [31:0] pc_in,
  input  logic        bp_en,
  input  logic [31:0] bp_pc,
  input  logic        skip_bp,
  input  logic [31:0] limit,
  input  logic [31:0] instr_cnt,
  input  logic        ign_bp,
  output logic        stop,
  output cause_e      cause
);
  logic hit_sent, hit_bp, hit_lim;

  always_comb begin
    hit_sent = (pc_in == HALT_PC);
    hit_bp   = bp_en && (pc_in == bp_pc) && !skip_bp && !ign_bp;
    hit_lim  = (limit != 32'd0) && (instr_cnt == limit);
    stop     = hit_sent || hit_bp || hit_lim;
    cause    = hit_sent ? CAUSE_SENTINEL :
               hit_bp   ? CAUSE_BREAK    :
               hit_lim  ? CAUSE_LIMIT    : CAUSE_NONE;
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer: gates core commit, holds core reset, reports halt cause.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter logic [31:0] HALT_PC    = HALT_PC_DEF,
  parameter logic [31:0] DEF_LIMIT  = 32'd10000,
  parameter int          RST_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rstn,
  cpu_run_ctrl_if.slave      cmd,
  input  logic [31:0]        pc_in,
  output logic               cpu_en,
  output logic               cpu_rstn,
  output logic               halted,
  output logic [2:0]         halt_cause,
  output logic [31:0]        instr_cnt
);
  localparam int RW = $clog2(RST_CYCLES + 1);

  state_e      state, state_nx;
  cause_e      cause_q, cause_nx, stop_cause;
  logic        boot;
  logic [RW-1:0] rst_cnt;
  logic        bp_en, skip_bp, err_q;
  logic [31:0] bp_pc, limit;
  logic        accept, halt_acc, stop;
  cmd_op_e     op;

  cpu_stop_detect #(.HALT_PC(HALT_PC)) u_stop (
    .pc_in, .bp_en, .bp_pc, .skip_bp, .limit, .instr_cnt,
    .ign_bp (state == ST_STEP),
    .stop,
    .cause  (stop_cause)
  );

  assign op            = cmd_op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = !boot && (state == ST_HALTED || state == ST_RUN);
  assign cmd.cmd_err   = err_q;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign halt_acc      = accept && (state == ST_RUN) && (op == OP_HALT);
  assign cpu_en        = (state == ST_RUN && !stop && !halt_acc) || (state == ST_STEP && !stop);
  assign cpu_rstn      = !(boot || state == ST_CPU_RST);
  assign halted        = (state == ST_HALTED);
  assign halt_cause    = cause_q;

  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    case (state)
      ST_HALTED:
        if (accept) begin
          case (op)
            OP_RUN:  state_nx = ST_RUN;
            OP_STEP: state_nx = ST_STEP;
            OP_RST:  state_nx = ST_CPU_RST;
            default: ;
          endcase
        end
      ST_RUN:
        if (stop) begin
          state_nx = ST_HALTED;
          cause_nx = stop_cause;
        end else if (halt_acc) begin
          state_nx = ST_HALTED;
          cause_nx = CAUSE_CMD;
        end
      ST_STEP: begin
        state_nx = ST_HALTED;
        cause_nx = stop ? stop_cause : CAUSE_STEP;
      end
      ST_CPU_RST:
        if (rst_cnt == RW'(1)) begin
          state_nx = ST_HALTED;
          cause_nx = CAUSE_NONE;
        end
      default: state_nx = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_HALTED;
      cause_q   <= CAUSE_NONE;
      boot      <= 1'b1;
      rst_cnt   <= '0;
      instr_cnt <= '0;
      limit     <= DEF_LIMIT;
      bp_en     <= 1'b0;
      bp_pc     <= '0;
      skip_bp   <= 1'b0;
      err_q     <= 1'b0;
    end else if (boot) begin
      // first clock after reset release always pulses the core reset
      boot      <= 1'b0;
      state     <= ST_CPU_RST;
      rst_cnt   <= RW'(RST_CYCLES);
      instr_cnt <= '0;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
      if (state_nx == ST_CPU_RST && state != ST_CPU_RST) begin
        rst_cnt   <= RW'(RST_CYCLES);
        instr_cnt <= '0;
      end else begin
        if (state == ST_CPU_RST) rst_cnt <= rst_cnt - RW'(1);
        if (cpu_en) instr_cnt <= instr_cnt + 32'd1;
      end
      err_q <= accept && (op == OP_ILL ||
               (state == ST_RUN && op != OP_HALT && op != OP_CLR_BP));
      if (accept && op == OP_CLR_BP) bp_en <= 1'b0;
      if (accept && state == ST_HALTED) begin
        case (op)
          OP_SET_BP:    begin bp_pc <= cmd.cmd_arg; bp_en <= 1'b1; end
          OP_SET_LIMIT: limit <= cmd.cmd_arg;
          // resuming from the breakpoint PC must not re-trigger it at once
          OP_RUN:       skip_bp <= (pc_in == bp_pc);
          default: ;
        endcase
      end
      if (state == ST_RUN && cpu_en) skip_bp <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny PC-sequencing core model.
module tb_cpu_run_ctrl;
  import cpu_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        cpu_en, cpu_rstn, halted;
  logic [2:0]  halt_cause;
  logic [31:0] instr_cnt;

  cpu_run_ctrl_if bif();

  cpu_run_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd        (bif.slave),
    .pc_in      (pc_in),
    .cpu_en     (cpu_en),
    .cpu_rstn   (cpu_rstn),
    .halted     (halted),
    .halt_cause (halt_cause),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  int   prog = 0;
  int   en_cnt = 0, en0 = 0;
  logic s_en, s_rstn, s_halted, s_ready, s_err;
  logic sent_viol = 1'b0;

  // program shapes: 0 reaches the sentinel after 7 instructions, 1 is linear, 2 spins
  function automatic logic [31:0] nxt(input logic [31:0] pc);
    case (prog)
      0:       return (pc == 32'd24) ? 32'hfffffffc : pc + 32'd4;
      1:       return pc + 32'd4;
      default: return pc;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    s_en = cpu_en; s_rstn = cpu_rstn; s_halted = halted;
    s_ready = bif.cmd_ready; s_err = bif.cmd_err;
    if (cpu_en) en_cnt++;
    if (cpu_en && pc_in == 32'hfffffffc) sent_viol = 1'b1;
    @(posedge clk); #1;
    if (!s_rstn) pc_in = 32'd0;
    else if (s_en) pc_in = nxt(pc_in);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    bif.cmd_valid = 1'b1; bif.cmd_op = op; bif.cmd_arg = arg;
    tick();
    bif.cmd_valid = 1'b0;
  endtask

  task automatic run_to_halt(input int bound);
    int n;
    n = 0;
    do begin tick(); n++; end while (!s_halted && n < bound);
    total++; if (!s_halted) begin bad++; $display("FAIL halt_timeout after %0d cycles", n); end
  endtask

  task automatic do_rst();
    send(OP_RST, 32'd0);
    run_to_halt(20);
  endtask

  task automatic test_reset();
    int lows;
    logic en_seen;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cpu_rstn !== 1'b0) begin bad++; $display("FAIL rst_cpu_rstn got=%b exp=0", cpu_rstn); end
    total++; if (bif.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bif.cmd_ready); end
    total++; if (cpu_en !== 1'b0 || bif.cmd_err !== 1'b0) begin bad++; $display("FAIL rst_en_err got=%b%b exp=00", cpu_en, bif.cmd_err); end
    total++; if (halted !== 1'b1 || halt_cause !== 3'd0 || instr_cnt !== 32'd0) begin
      bad++; $display("FAIL rst_state got=%b/%0d/%0d exp=1/0/0", halted, halt_cause, instr_cnt); end
    lows = 1; en_seen = 1'b0;
    #2 rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_en) en_seen = 1'b1;
      if (cpu_rstn) break;
      lows++;
    end
    total++; if (lows != 5) begin bad++; $display("FAIL rst_len got=%0d exp=5", lows); end
    total++; if (en_seen !== 1'b0) begin bad++; $display("FAIL rst_cpu_en got=1 exp=0"); end
    total++; if (halted !== 1'b1 || halt_cause !== 3'd0 || instr_cnt !== 32'd0) begin
      bad++; $display("FAIL rst_done got=%b/%0d/%0d exp=1/0/0", halted, halt_cause, instr_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_sentinel();
    prog = 0;
    send(OP_RUN, 32'd0);
    run_to_halt(50);
    total++; if (instr_cnt !== 32'd7) begin bad++; $display("FAIL sent_cnt got=%0d exp=7", instr_cnt); end
    total++; if (halt_cause !== 3'd2) begin bad++; $display("FAIL sent_cause got=%0d exp=2", halt_cause); end
    total++; if (pc_in !== 32'hfffffffc || cpu_en !== 1'b0) begin
      bad++; $display("FAIL sent_pc_en got=%h/%b exp=fffffffc/0", pc_in, cpu_en); end
    total++; if (sent_viol !== 1'b0) begin bad++; $display("FAIL sent_commit got=1 exp=0"); end
  endtask

  task automatic test_breakpoint();
    do_rst();
    total++; if (instr_cnt !== 32'd0 || pc_in !== 32'd0) begin
      bad++; $display("FAIL bp_rst got=%0d/%h exp=0/0", instr_cnt, pc_in); end
    prog = 1;
    send(OP_SET_BP, 32'h10);
    send(OP_RUN, 32'd0);
    run_to_halt(50);
    total++; if (instr_cnt !== 32'd4 || pc_in !== 32'h10) begin
      bad++; $display("FAIL bp_hit got=%0d/%h exp=4/10", instr_cnt, pc_in); end
    total++; if (halt_cause !== 3'd3) begin bad++; $display("FAIL bp_cause got=%0d exp=3", halt_cause); end
    send(OP_RUN, 32'd0);
    tick();
    total++; if (s_en !== 1'b1) begin bad++; $display("FAIL bp_skip got=%b exp=1", s_en); end
    tick(); tick();
    send(OP_HALT, 32'd0);
    total++; if (s_en !== 1'b0) begin bad++; $display("FAIL halt_en got=%b exp=0", s_en); end
    total++; if (instr_cnt !== 32'd7 || pc_in !== 32'h1c) begin
      bad++; $display("FAIL bp_resume got=%0d/%h exp=7/1c", instr_cnt, pc_in); end
    total++; if (halt_cause !== 3'd1 || halted !== 1'b1) begin
      bad++; $display("FAIL bp_halt got=%0d/%b exp=1/1", halt_cause, halted); end
  endtask

  task automatic test_limit();
    do_rst();
    prog = 2;
    send(OP_SET_LIMIT, 32'd5);
    send(OP_RUN, 32'd0);
    run_to_halt(50);
    total++; if (instr_cnt !== 32'd5 || halt_cause !== 3'd4) begin
      bad++; $display("FAIL lim_hit got=%0d/%0d exp=5/4", instr_cnt, halt_cause); end
    en0 = en_cnt;
    send(OP_STEP, 32'd0);
    tick();
    total++; if (en_cnt != en0) begin bad++; $display("FAIL lim_step got=%0d exp=0 pulses", en_cnt - en0); end
    total++; if (halt_cause !== 3'd4 || halted !== 1'b1 || instr_cnt !== 32'd5) begin
      bad++; $display("FAIL lim_step_state got=%0d/%b/%0d exp=4/1/5", halt_cause, halted, instr_cnt); end
    send(OP_SET_LIMIT, 32'd0);
  endtask

  task automatic test_step_halt();
    prog = 1;
    en0 = en_cnt;
    send(OP_STEP, 32'd0);
    tick(); tick();
    total++; if (en_cnt - en0 != 1) begin bad++; $display("FAIL step_pulses got=%0d exp=1", en_cnt - en0); end
    total++; if (halt_cause !== 3'd5 || instr_cnt !== 32'd6 || pc_in !== 32'd4) begin
      bad++; $display("FAIL step_state got=%0d/%0d/%h exp=5/6/4", halt_cause, instr_cnt, pc_in); end
    send(OP_HALT, 32'd0);
    tick();
    total++; if (s_err !== 1'b0 || halt_cause !== 3'd5) begin
      bad++; $display("FAIL halt_noop got=%b/%0d exp=0/5", s_err, halt_cause); end
    send(OP_ILL, 32'd0);
    tick();
    total++; if (s_err !== 1'b1 || halted !== 1'b1 || halt_cause !== 3'd5) begin
      bad++; $display("FAIL illegal got=%b/%b/%0d exp=1/1/5", s_err, halted, halt_cause); end
    do_rst();
    send(OP_RUN, 32'd0);
    tick(); tick();
    send(OP_HALT, 32'd0);
    total++; if (instr_cnt !== 32'd2 || halt_cause !== 3'd1) begin
      bad++; $display("FAIL halt_cmd got=%0d/%0d exp=2/1", instr_cnt, halt_cause); end
    send(OP_RUN, 32'd0);
    send(OP_SET_BP, 32'h40);
    tick();
    total++; if (s_err !== 1'b1) begin bad++; $display("FAIL run_err got=%b exp=1", s_err); end
    total++; if (bif.cmd_err !== 1'b0) begin bad++; $display("FAIL run_err_pulse got=%b exp=0", bif.cmd_err); end
    run_to_halt(20);
    total++; if (instr_cnt !== 32'd4 || pc_in !== 32'h10 || halt_cause !== 3'd3) begin
      bad++; $display("FAIL run_bp_kept got=%0d/%h/%0d exp=4/10/3", instr_cnt, pc_in, halt_cause); end
  endtask

  task automatic test_simultaneous();
    do_rst();
    total++; if (halt_cause !== 3'd0) begin bad++; $display("FAIL sim_rst_cause got=%0d exp=0", halt_cause); end
    send(OP_RUN, 32'd0);
    repeat (4) tick();
    send(OP_HALT, 32'd0);
    total++; if (s_en !== 1'b0) begin bad++; $display("FAIL sim_en got=%b exp=0", s_en); end
    total++; if (halt_cause !== 3'd3 || instr_cnt !== 32'd4) begin
      bad++; $display("FAIL sim_cause got=%0d/%0d exp=3/4", halt_cause, instr_cnt); end
    send(OP_RST, 32'd0);
    tick();
    total++; if (s_ready !== 1'b0 || s_rstn !== 1'b0) begin
      bad++; $display("FAIL cpurst_ready got=%b/%b exp=0/0", s_ready, s_rstn); end
    run_to_halt(20);
    total++; if (instr_cnt !== 32'd0 || pc_in !== 32'd0 || halt_cause !== 3'd0) begin
      bad++; $display("FAIL sim_rst got=%0d/%h/%0d exp=0/0/0", instr_cnt, pc_in, halt_cause); end
    send(OP_RUN, 32'd0);
    run_to_halt(50);
    total++; if (instr_cnt !== 32'd4 || pc_in !== 32'h10 || halt_cause !== 3'd3) begin
      bad++; $display("FAIL sim_bp_retained got=%0d/%h/%0d exp=4/10/3", instr_cnt, pc_in, halt_cause); end
  endtask

  initial begin
    bif.cmd_valid = 1'b0; bif.cmd_op = 3'd0; bif.cmd_arg = 32'd0;
    test_reset();
    test_sentinel();
    test_breakpoint();
    test_limit();
    test_step_halt();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/debug sequencer for the single-cycle RISC-V core (sccomp). It gates instruction commit through a clock-enable and accepts RUN/STEP/HALT/breakpoint/limit/reset commands over a valid/ready port. It stops the core on the sentinel PC 0xfffffffc, on a breakpoint, or on an instruction-count limit, and reports the cause. In hardware it replaces the bench-side stop/counter logic and sits between the host/debug interface and the CPU's enable and reset inputs.

Parameters:
HALT_PC, 32'hfffffffc, sentinel PC; core must not commit while at this PC
DEF_LIMIT, 10000, instruction limit after reset; 0 = unlimited
RST_CYCLES, 4, cycles cpu_rstn is held low by CMD_RST; minimum 1

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clk rise
cmd_op  in  3  0 RUN, 1 STEP, 2 HALT, 3 SET_BP, 4 CLR_BP, 5 SET_LIMIT, 6 RST; 7 illegal
cmd_arg  in  32  breakpoint PC (SET_BP) or limit (SET_LIMIT)
pc_in  in  32  core's current PC (before commit)
cpu_en  out  1  core commits one instruction at this clk rise
cpu_rstn  out  1  active-low reset to core, synchronous to clk
halted  out  1  state == HALTED
halt_cause  out  3  0 NONE, 1 CMD, 2 SENTINEL, 3 BREAK, 4 LIMIT, 5 STEP
instr_cnt  out  32  instructions committed since last reset or RST
cmd_err  out  1  one-cycle pulse when a command is dropped

Behaviour:
- Reset (async, rstn=0) sets:
  - state HALTED, cause NONE, instr_cnt 0, limit DEF_LIMIT.
  - bp_en 0, bp_pc 0, skip_bp 0.
  - cpu_en 0, cpu_rstn 0, cmd_ready 0, cmd_err 0.
- First clk after rstn rises: state goes to CPU_RST with rst_cnt = RST_CYCLES.
- States: HALTED, RUN, STEP, CPU_RST.
- cmd_ready = 1 in HALTED and RUN; 0 in STEP and CPU_RST.
- stop = (pc_in == HALT_PC), else (bp_en && pc_in == bp_pc && !skip_bp), else (limit != 0 && instr_cnt == limit).
  - Cause priority is SENTINEL > BREAK > LIMIT > CMD.
- cpu_en is combinational: (RUN && !stop && !halt_accept) || (STEP && !stop).
- instr_cnt increments on every cpu_en cycle and wraps at 2^32.
- HALTED:
  - RUN goes to RUN. skip_bp is set if pc_in == bp_pc.
  - STEP goes to STEP.
  - SET_BP loads bp_pc and sets bp_en=1. CLR_BP clears bp_en.
  - SET_LIMIT loads limit. RST goes to CPU_RST.
  - HALT is a no-op and cause is unchanged.
- RUN:
  - If stop, go to HALTED with cause from priority.
  - Else if HALT accepted, cpu_en=0 that cycle and go to HALTED with cause CMD.
  - CLR_BP is accepted and applied.
  - Any other command pulses cmd_err and is dropped.
  - skip_bp clears after the first committed cycle.
- STEP (exactly 1 cycle):
  - Breakpoint is ignored.
  - If pc_in == HALT_PC or the limit is reached: cpu_en=0, go to HALTED with that cause.
  - Otherwise commit one instruction and go to HALTED with cause STEP.
- CPU_RST:
  - cpu_rstn=0 and cpu_en=0. instr_cnt is cleared on entry.
  - rst_cnt decrements each cycle; at 1, go to HALTED with cause NONE.
  - cpu_rstn returns to 1 from the next cycle.
- Illegal op 7: cmd_err pulse, no state change.
- bp_pc and limit are preserved across CMD_RST; only rstn clears them.

Decomposition:
- Package cpu_dbg_pkg holds:
  - state enum;
  - cmd_op codes;
  - halt_cause codes;
  - HALT_PC default.
- One sub-module, cpu_stop_detect: combinational stop/cause compare of pc_in, bp and limit.
- Sequencing and counters stay in cpu_run_ctrl.

Test Plan:
- Reset release: rstn low for 20 ns. Expect cpu_rstn low for 1+RST_CYCLES clocks, then halted=1, cause=0, instr_cnt=0, cpu_en=0 throughout.
- RUN to sentinel: program whose PC reaches 0xfffffffc after 7 instructions. Expect instr_cnt=7, halted, cause=2, and cpu_en=0 while pc_in=0xfffffffc.
- Breakpoint:
  - SET_BP 0x10, then RUN from 0. Expect halt at pc_in=0x10, instr_cnt=4, cause=3.
  - RUN again. Expect the first instruction committed (skip) and execution continuing past 0x10.
- Limit: SET_LIMIT 5, then RUN on an infinite loop. Expect halt with instr_cnt=5, cause=4; a further STEP keeps cpu_en=0.
- STEP and HALT:
  - STEP. Expect exactly one cpu_en pulse and cause=5.
  - RUN, then HALT on cycle 3. Expect instr_cnt=2, cause=1.
  - SET_BP during RUN. Expect a cmd_err pulse and bp_en unchanged.
- Simultaneous: HALT issued in the same cycle pc_in==bp_pc. Expect cause=3 (BREAK), cpu_en=0. Then RST: instr_cnt=0 while bp_pc is retained.
